// File: rtl/heartbeat_pkg.sv
// Shared constants and FSM encoding for the heartbeat window reader.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package heartbeat_pkg;

  localparam int HB_DEPTH = 100;  // samples per heartbeat window
  localparam int HB_WIDTH = 16;   // sample width in bits
  localparam int HB_IDX_W = 7;    // sample index width
  localparam int HB_CNT_W = 16;   // completed-window counter width

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    DRAIN    = 3'd1,
    FLUSH    = 3'd2,
    SUMMARY  = 3'd3,
    RELEASE  = 3'd4,
    WAIT_CLR = 3'd5
  } hb_state_e;

endpackage

// File: rtl/hb_extrema.sv
// Running unsigned max/min/argmax over one window of samples.
// Latency: result includes a sample one cycle after it is presented with in_vld.
// Backpressure: none; accepts a sample every cycle.
// Ports: clear zeroes the tracker, seed marks the first sample of a window,
//        in_vld/in_dat/in_idx carry the sample, max_*/min_dat are the running result.
module hb_extrema
  import heartbeat_pkg::*;
#(
  parameter int WIDTH = HB_WIDTH,
  parameter int IDX_W = HB_IDX_W
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             in_vld,
  input  logic             seed,
  input  logic [WIDTH-1:0] in_dat,
  input  logic [IDX_W-1:0] in_idx,
  output logic [WIDTH-1:0] max_dat,
  output logic [IDX_W-1:0] max_idx,
  output logic [WIDTH-1:0] min_dat
);

  logic [WIDTH-1:0] max_dat_q, max_dat_d;
  logic [IDX_W-1:0] max_idx_q, max_idx_d;
  logic [WIDTH-1:0] min_dat_q, min_dat_d;

  always_comb begin
    max_dat_d = max_dat_q;
    max_idx_d = max_idx_q;
    min_dat_d = min_dat_q;
    if (clear) begin
      max_dat_d = '0;
      max_idx_d = '0;
      min_dat_d = '0;
    end else if (in_vld) begin
      if (seed) begin
        max_dat_d = in_dat;
        max_idx_d = in_idx;
        min_dat_d = in_dat;
      end else begin
        // Strict compare: equal values keep the earlier index.
        if (in_dat > max_dat_q) begin
          max_dat_d = in_dat;
          max_idx_d = in_idx;
        end
        if (in_dat < min_dat_q) begin
          min_dat_d = in_dat;
        end
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      max_dat_q <= '0;
      max_idx_q <= '0;
      min_dat_q <= '0;
    end else begin
      max_dat_q <= max_dat_d;
      max_idx_q <= max_idx_d;
      min_dat_q <= min_dat_d;
    end
  end

  assign max_dat = max_dat_q;
  assign max_idx = max_idx_q;
  assign min_dat = min_dat_q;

endmodule

// File: rtl/heartbeat_reader.sv
// Drains a full sample buffer, forwards each sample and publishes the window peak/trough.
// Latency: sample k out at T+3+k after full seen at T; summary at T+DEPTH+3; release at T+DEPTH+4.
// Backpressure: none on the sample stream; buffer is held until full drops after release.
// Ports: full/buf_data from the buffer, read/buf_release_n to it; sample_* stream out;
//        peak_*/trough_value/beat_done/beat_count summarise each completed window.
module heartbeat_reader
  import heartbeat_pkg::*;
#(
  parameter int DEPTH = HB_DEPTH,
  parameter int WIDTH = HB_WIDTH
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                full,
  input  logic [WIDTH-1:0]    buf_data,
  output logic                read,
  output logic                buf_release_n,
  output logic [WIDTH-1:0]    sample_out,
  output logic                sample_valid,
  output logic [HB_IDX_W-1:0] sample_index,
  output logic [WIDTH-1:0]    peak_value,
  output logic [HB_IDX_W-1:0] peak_index,
  output logic [WIDTH-1:0]    trough_value,
  output logic                beat_done,
  output logic [HB_CNT_W-1:0] beat_count
);

  localparam logic [HB_IDX_W-1:0] LAST_IDX = HB_IDX_W'(DEPTH - 1);

  hb_state_e             state_q, state_d;
  logic                  read_q, read_d;
  logic                  rd_dly_q, rd_dly_d;  // read delayed one cycle: buf_data is valid
  logic [HB_IDX_W-1:0]   rd_cnt_q, rd_cnt_d;
  logic [HB_IDX_W-1:0]   cap_cnt_q, cap_cnt_d;
  logic [WIDTH-1:0]      sample_out_q, sample_out_d;
  logic                  sample_valid_q, sample_valid_d;
  logic [HB_IDX_W-1:0]   sample_index_q, sample_index_d;
  logic [WIDTH-1:0]      peak_value_q, peak_value_d;
  logic [HB_IDX_W-1:0]   peak_index_q, peak_index_d;
  logic [WIDTH-1:0]      trough_value_q, trough_value_d;
  logic                  beat_done_q, beat_done_d;
  logic [HB_CNT_W-1:0]   beat_count_q, beat_count_d;
  logic                  release_n_q, release_n_d;

  logic                  ext_clear;
  logic [WIDTH-1:0]      ext_max;
  logic [HB_IDX_W-1:0]   ext_max_idx;
  logic [WIDTH-1:0]      ext_min;

  hb_extrema #(
    .WIDTH (WIDTH),
    .IDX_W (HB_IDX_W)
  ) u_extrema (
    .clock   (clock),
    .reset   (reset),
    .clear   (ext_clear),
    .in_vld  (rd_dly_q),
    .seed    (cap_cnt_q == '0),
    .in_dat  (buf_data),
    .in_idx  (cap_cnt_q),
    .max_dat (ext_max),
    .max_idx (ext_max_idx),
    .min_dat (ext_min)
  );

  always_comb begin
    state_d        = state_q;
    read_d         = read_q;
    rd_dly_d       = read_q;
    rd_cnt_d       = rd_cnt_q;
    cap_cnt_d      = cap_cnt_q;
    sample_out_d   = sample_out_q;
    sample_valid_d = rd_dly_q;
    sample_index_d = sample_index_q;
    peak_value_d   = peak_value_q;
    peak_index_d   = peak_index_q;
    trough_value_d = trough_value_q;
    beat_done_d    = 1'b0;
    beat_count_d   = beat_count_q;
    release_n_d    = 1'b1;
    ext_clear      = 1'b0;

    // Capture path runs independently of the FSM: whatever was read is forwarded.
    if (rd_dly_q) begin
      sample_out_d   = buf_data;
      sample_index_d = cap_cnt_q;
      cap_cnt_d      = cap_cnt_q + HB_IDX_W'(1);
    end

    case (state_q)
      IDLE: begin
        if (full) begin
          state_d   = DRAIN;
          read_d    = 1'b1;
          rd_cnt_d  = '0;
          cap_cnt_d = '0;
          ext_clear = 1'b1;
        end
      end
      DRAIN: begin
        // read must stay high for the whole window regardless of full.
        if (rd_cnt_q == LAST_IDX) begin
          read_d  = 1'b0;
          state_d = FLUSH;
        end else begin
          rd_cnt_d = rd_cnt_q + HB_IDX_W'(1);
        end
      end
      FLUSH: begin
        // The last sample is on sample_out now; the tracker already includes it.
        if (sample_valid_q && (sample_index_q == LAST_IDX)) begin
          state_d        = SUMMARY;
          beat_done_d    = 1'b1;
          peak_value_d   = ext_max;
          peak_index_d   = ext_max_idx;
          trough_value_d = ext_min;
          beat_count_d   = beat_count_q + HB_CNT_W'(1);
        end
      end
      SUMMARY: begin
        state_d     = RELEASE;
        release_n_d = 1'b0;
      end
      RELEASE: begin
        state_d = WAIT_CLR;
      end
      WAIT_CLR: begin
        // Waiting for full to drop guarantees a window is never drained twice.
        if (!full) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q        <= IDLE;
      read_q         <= 1'b0;
      rd_dly_q       <= 1'b0;
      rd_cnt_q       <= '0;
      cap_cnt_q      <= '0;
      sample_out_q   <= '0;
      sample_valid_q <= 1'b0;
      sample_index_q <= '0;
      peak_value_q   <= '0;
      peak_index_q   <= '0;
      trough_value_q <= '0;
      beat_done_q    <= 1'b0;
      beat_count_q   <= '0;
      release_n_q    <= 1'b1;
    end else begin
      state_q        <= state_d;
      read_q         <= read_d;
      rd_dly_q       <= rd_dly_d;
      rd_cnt_q       <= rd_cnt_d;
      cap_cnt_q      <= cap_cnt_d;
      sample_out_q   <= sample_out_d;
      sample_valid_q <= sample_valid_d;
      sample_index_q <= sample_index_d;
      peak_value_q   <= peak_value_d;
      peak_index_q   <= peak_index_d;
      trough_value_q <= trough_value_d;
      beat_done_q    <= beat_done_d;
      beat_count_q   <= beat_count_d;
      release_n_q    <= release_n_d;
    end
  end

  assign read          = read_q;
  assign buf_release_n = release_n_q;
  assign sample_out    = sample_out_q;
  assign sample_valid  = sample_valid_q;
  assign sample_index  = sample_index_q;
  assign peak_value    = peak_value_q;
  assign peak_index    = peak_index_q;
  assign trough_value  = trough_value_q;
  assign beat_done     = beat_done_q;
  assign beat_count    = beat_count_q;

endmodule

// File: tb/tb_heartbeat_reader.sv
// Directed bench for heartbeat_reader with a behavioural sample buffer.
// Latency: checks every cycle of each window against hand-derived timing.
// Backpressure: n/a.
module tb_heartbeat_reader;

  logic        clock;
  logic        reset;
  logic        full;
  logic [15:0] buf_data;
  logic        read;
  logic        buf_release_n;
  logic [15:0] sample_out;
  logic        sample_valid;
  logic [6:0]  sample_index;
  logic [15:0] peak_value;
  logic [6:0]  peak_index;
  logic [15:0] trough_value;
  logic        beat_done;
  logic [15:0] beat_count;

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] mem [0:99];
  int          rd_ptr;

  heartbeat_reader #(
    .DEPTH (100),
    .WIDTH (16)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .full          (full),
    .buf_data      (buf_data),
    .read          (read),
    .buf_release_n (buf_release_n),
    .sample_out    (sample_out),
    .sample_valid  (sample_valid),
    .sample_index  (sample_index),
    .peak_value    (peak_value),
    .peak_index    (peak_index),
    .trough_value  (trough_value),
    .beat_done     (beat_done),
    .beat_count    (beat_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Buffer model: data one cycle after each read-high cycle, pointer rewinds when read is low.
  always @(posedge clock) begin
    if (read) begin
      buf_data <= mem[rd_ptr];
      rd_ptr   <= rd_ptr + 1;
    end else begin
      rd_ptr   <= 0;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic load_ramp();
    for (int i = 0; i < 100; i++) mem[i] = 16'(i);
  endtask

  task automatic load_pulse();
    for (int i = 0; i < 100; i++) mem[i] = 16'h0500;
    mem[40] = 16'hFFFF;
    mem[70] = 16'hFFFF;
  endtask

  task automatic load_desc();
    for (int i = 0; i < 100; i++) mem[i] = 16'(1000 - 7 * i);
  endtask

  // Called at a negedge. Raises full; the next posedge is edge T. Cycle T+k is
  // sampled at the k-th following negedge. drop_at>0 lowers full after cycle T+drop_at.
  task automatic run_window(input int drop_at, input logic [15:0] ep, input logic [6:0] epi,
                            input logic [15:0] et, input logic [15:0] ec);
    full = 1'b1;
    @(posedge clock);
    for (int k = 1; k <= 112; k++) begin
      @(negedge clock);
      check_eq("read", read, 32'(k <= 100));
      check_eq("sample_valid", sample_valid, 32'(k >= 3 && k <= 102));
      if (k >= 3 && k <= 102) begin
        check_eq("sample_index", sample_index, 32'(k - 3));
        check_eq("sample_out", sample_out, 32'(mem[k - 3]));
      end
      check_eq("beat_done", beat_done, 32'(k == 103));
      check_eq("buf_release_n", buf_release_n, 32'(k != 104));
      if (k == 103) begin
        check_eq("peak_value", peak_value, 32'(ep));
        check_eq("peak_index", peak_index, 32'(epi));
        check_eq("trough_value", trough_value, 32'(et));
        check_eq("beat_count", beat_count, 32'(ec));
      end
      if (k == drop_at) full = 1'b0;
    end
    check_eq("peak_hold", peak_value, 32'(ep));
    check_eq("count_hold", beat_count, 32'(ec));
    full = 1'b0;
    repeat (2) @(negedge clock);
    check_eq("idle_read", read, 32'd0);
  endtask

  initial begin
    reset    = 1'b0;
    full     = 1'b0;
    buf_data = '0;
    rd_ptr   = 0;
    load_ramp();
    repeat (3) @(negedge clock);

    check_eq("rst_read", read, 32'd0);
    check_eq("rst_release_n", buf_release_n, 32'd1);
    check_eq("rst_valid", sample_valid, 32'd0);
    check_eq("rst_beat_done", beat_done, 32'd0);
    check_eq("rst_sample_out", sample_out, 32'd0);
    check_eq("rst_peak", peak_value, 32'd0);
    check_eq("rst_trough", trough_value, 32'd0);
    check_eq("rst_count", beat_count, 32'd0);

    reset = 1'b1;
    @(negedge clock);

    // Ramp window; full held high well past release must not re-trigger.
    load_ramp();
    run_window(0, 16'd99, 7'd99, 16'd0, 16'd1);

    // Two equal maxima: first index wins.
    load_pulse();
    run_window(0, 16'hFFFF, 7'd40, 16'h0500, 16'd2);

    // full drops mid-window: window still completes.
    load_desc();
    run_window(50, 16'd1000, 7'd0, 16'd307, 16'd3);

    // Reset in the middle of a window.
    load_ramp();
    full = 1'b1;
    @(posedge clock);
    for (int k = 1; k <= 30; k++) @(negedge clock);
    check_eq("pre_rst_read", read, 32'd1);
    reset = 1'b0;
    #1;
    check_eq("mid_rst_read", read, 32'd0);
    check_eq("mid_rst_valid", sample_valid, 32'd0);
    check_eq("mid_rst_peak", peak_value, 32'd0);
    check_eq("mid_rst_pidx", peak_index, 32'd0);
    check_eq("mid_rst_trough", trough_value, 32'd0);
    check_eq("mid_rst_count", beat_count, 32'd0);
    repeat (3) @(negedge clock);
    check_eq("held_rst_peak", peak_value, 32'd0);
    reset = 1'b1;
    run_window(0, 16'd99, 7'd99, 16'd0, 16'd1);

    // Counter wrap: preload near the top.
    force dut.beat_count_q = 16'hFFFE;
    @(negedge clock);
    release dut.beat_count_q;
    @(negedge clock);
    check_eq("forced_count", beat_count, 32'hFFFE);
    load_pulse();
    run_window(0, 16'hFFFF, 7'd40, 16'h0500, 16'hFFFF);
    load_ramp();
    run_window(0, 16'd99, 7'd99, 16'd0, 16'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
